multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle RV32I subset datapath with a shared memory, an instruction register, a single ALU and a register file.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.
- Decodes opcode, funct3 and funct7[5] from the external instruction register and drives all datapath enables and mux selects.
- Stalls on a memory ready handshake, traps illegal instructions into a sticky error state, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  7  Instr[6:0] from the instruction register.
- funct3  input  3  Instr[14:12].
- funct7_bit5  input  1  Instr[30].
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read or write this cycle.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  output  1  instruction register load enable.
- PCWrite  output  1  PC load enable; equals PCUpdate | (Branch & Zero).
- MemWrite  output  1  memory write strobe.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  output  2  ALU B select: 00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALUResult.
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal  output  1  high while the FSM is in S_ERR.
- instret  output  CNT_W  count of retired instructions.

Behaviour:
General
- Moore outputs decoded from state. Exceptions: IRWrite and PCUpdate are gated by mem_ready, and PCWrite depends on Zero.
- Any output not listed for a state is 0. ALUOp is internal.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00.

Reset
- rst=1 at a clock edge: state <= FETCH, instret <= 0.
- rst has priority over every other event, including mid-instruction. A pending MemWrite or RegWrite is dropped.
- While rst=1 the outputs still decode as FETCH, but no state or counter change occurs.

States and transitions
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=mem_ready, PCUpdate=mem_ready.
  - Go to DECODE when mem_ready=1, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - op 3 or 35 -> MEMADR; op 51 -> EXEC_R; op 19 -> EXEC_I; op 111 -> JAL; op 99 -> BEQ.
  - R-type or I-type with funct3 not in {000, 010, 110, 111} -> S_ERR.
  - beq with funct3 != 000 -> S_ERR.
  - Any other op -> S_ERR.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD, sw -> MEMWR.
- MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB when mem_ready=1, else stay.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00.
  - MemWrite=1 every cycle until mem_ready=1, then go to FETCH.
  - Exactly one write completes per sw.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
- S_ERR: all enables 0, illegal=1. Sticky until rst.

ALU decoder
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10, selected by funct3:
  - 000 -> sub if op[5] & funct7_bit5, else add. addi is always add.
  - 010 -> slt; 110 -> or; 111 -> and.
- ALUOp 11 -> add.

Retire counter
- instret increments by 1 on each edge leaving MEMWB, ALUWB or BEQ, and on the edge leaving MEMWR when mem_ready=1.
- Wraps modulo 2^CNT_W. Never changes in S_ERR.

Latency with mem_ready tied to 1
- beq 3 cycles; sw 4 cycles; R-type, I-type and jal 4 cycles; lw 5 cycles.
- Each cycle mem_ready=0 in FETCH, MEMREAD or MEMWR adds one cycle.

Test Plan:
1. rst=1 for 2 cycles, then addi x8,x0,6 (op=19, f3=0), mem_ready=1.
   - States FETCH, DECODE, EXEC_I, ALUWB.
   - ALUControl=000 in EXEC_I; RegWrite=1 only in cycle 4; instret=1.
2. sub x19,x8,x9 (op=51, f3=0, f7b5=1), then add (f7b5=0).
   - ALUControl=001, then 000, in EXEC_R.
   - or (f3=110) -> 011; and (f3=111) -> 010; slt (f3=010) -> 101.
3. lw (op=3) with mem_ready=0 for the first 2 MEMREAD cycles.
   - 7 cycles total.
   - AdrSrc=1 throughout MEMREAD; RegWrite=1, ResultSrc=01 in MEMWB; instret +1.
4. sw (op=35) with mem_ready=0 for 3 cycles in MEMWR.
   - MemWrite=1 for 4 consecutive cycles, then 0 in FETCH.
   - ImmSrc=01; instret +1 only after the ready cycle.
5. beq (op=99) with Zero=1, then repeat with Zero=0.
   - PCWrite=1 in BEQ in the first case, 0 in the second.
   - ALUControl=001, ImmSrc=10.
   - jal (op=111): PCWrite=1 in FETCH and JAL; RegWrite in ALUWB.
6. op=0x7F, or R-type with f3=001.
   - FETCH, DECODE, then S_ERR; illegal=1 and outputs stay 0 for 10 cycles.
   - rst=1 returns to FETCH with instret=0.
   - Also assert rst during MEMWR: no further MemWrite, state FETCH next cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RV32I-subset datapath (lw, sw, R-type, I-type
// ALU, beq, jal) built around a shared memory, an instruction register, one
// ALU and a register file. The controller decodes the instruction register
// fields and drives every datapath enable and mux select.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   op, funct3,        instruction register fields Instr[6:0], Instr[14:12],
//   funct7_bit5        Instr[30]
//   Zero               ALU zero flag (qualifies beq)
//   mem_ready          memory finished the current read/write this cycle
//   AdrSrc             memory address select (0 = PC, 1 = ALUOut)
//   IRWrite, PCWrite   instruction register / PC load enables
//   MemWrite, RegWrite memory write strobe / register file write enable
//   ALUSrcA, ALUSrcB   ALU operand selects
//   ResultSrc          result bus select
//   ALUControl         ALU operation
//   ImmSrc             immediate format, decoded from op in every state
//   illegal            high while trapped in the error state
//   instret            retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_bit5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_JAL     = 4'd8,
        S_ALUWB   = 4'd9,
        S_BEQ     = 4'd10,
        S_ERR     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_JAL = 7'd111;
    localparam logic [6:0] OP_BEQ = 7'd99;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t           state_q, state_d;
    state_t           out_state_s;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire_s;
    logic             pc_update_s;
    logic             branch_s;
    logic [1:0]       alu_op_s;

    // Only add/sub, slt, or and and are implemented for the ALU formats.
    function automatic logic alu_f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // State register and retire counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic and retire detection.
    always_comb begin
        state_d  = state_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R: begin
                        if (alu_f3_legal(funct3)) state_d = S_EXEC_R;
                        else                      state_d = S_ERR;
                    end
                    OP_I: begin
                        if (alu_f3_legal(funct3)) state_d = S_EXEC_I;
                        else                      state_d = S_ERR;
                    end
                    OP_JAL: state_d = S_JAL;
                    OP_BEQ: begin
                        if (funct3 == 3'b000) state_d = S_BEQ;
                        else                  state_d = S_ERR;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) state_d = S_MEMWR;
                else             state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_MEMWR: begin
                // The store retires only on the cycle memory accepts it.
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXEC_R: state_d = S_ALUWB;
            S_EXEC_I: state_d = S_ALUWB;
            S_JAL:    state_d = S_ALUWB;
            S_ALUWB: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_BEQ: begin
                state_d  = S_FETCH;
                retire_s = 1'b1;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase

        if (retire_s) instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        else          instret_d = instret_q;
    end

    // While reset is held the outputs look like FETCH, which also drops any
    // write strobe that was pending in the interrupted instruction.
    always_comb begin
        if (rst) out_state_s = S_FETCH;
        else     out_state_s = state_q;
    end

    // Moore output decode; IRWrite/PCUpdate are qualified by mem_ready.
    always_comb begin
        AdrSrc      = 1'b0;
        IRWrite     = 1'b0;
        pc_update_s = 1'b0;
        branch_s    = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        alu_op_s    = 2'b00;
        illegal     = 1'b0;
        case (out_state_s)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                IRWrite     = mem_ready;
                pc_update_s = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA  = 2'b10;
                alu_op_s = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                alu_op_s = 2'b10;
            end
            S_JAL: begin
                // OldPC + 4 is the link value; ALUOut (target) loads the PC.
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pc_update_s = 1'b1;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                alu_op_s = 2'b01;
                branch_s = 1'b1;
            end
            S_ERR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
    end

    assign PCWrite = pc_update_s | (branch_s & Zero);
    assign instret = instret_q;

    // ALU decoder; addi never subtracts because op[5] is clear for I-type.
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op_s)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] & funct7_bit5) ALUControl = ALU_SUB;
                        else                     ALUControl = ALU_ADD;
                    end
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

endmodule
